hc_stream_xor: RTL and testbench

- Consumer side of the HC keystream interface; the requesting end that drives the cipher core's init/next and accepts s/s_valid.
- Prefetches keystream words into a small buffer and XORs them with a valid/ready data stream.
- Encryption and decryption are the same operation.
- Sits between the host data path and the HC core.

---
 rtl/hc_pkg.sv | 23 ++
 rtl/hc_ks_fifo.sv | 55 +++++
 rtl/hc_stream_xor.sv | 184 ++++++++++++++++++
 tb/tb_hc_stream_xor.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// Shared definitions for the HC keystream consumer.
// Word/key widths and the stream-XOR FSM encoding.
package hc_pkg;

    localparam int HC_WORD_W = 32;
    localparam int HC_KEY_W  = 128;
    localparam int HC_IV_W   = 128;

    typedef enum logic [1:0] {
        HC_XOR_IDLE      = 2'd0,
        HC_XOR_INIT      = 2'd1,
        HC_XOR_WAIT_INIT = 2'd2,
        HC_XOR_RUN       = 2'd3
    } hc_xor_state_t;

    function automatic logic [HC_WORD_W-1:0] hc_xor_word(
        input logic [HC_WORD_W-1:0] data,
        input logic [HC_WORD_W-1:0] ks
    );
        return data ^ ks;
    endfunction

endpackage

// File: rtl/hc_ks_fifo.sv
// Keystream prefetch FIFO: KS_DEPTH x 32, circular pointers.
// Flush empties it in one cycle; push and pop may coincide.
module hc_ks_fifo
    import hc_pkg::*;
#(
    parameter int KS_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic [HC_WORD_W-1:0]      push_data,
    input  logic                      pop,
    output logic [HC_WORD_W-1:0]      head,
    output logic [$clog2(KS_DEPTH):0] count
);

    localparam int AW = $clog2(KS_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [HC_WORD_W-1:0] mem [KS_DEPTH];

    assign head = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; no reset needed, occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/hc_stream_xor.sv
// HC keystream consumer: keys the core, prefetches keystream,
// and XORs it onto a valid/ready data stream.
module hc_stream_xor
    import hc_pkg::*;
#(
    parameter int KS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [HC_KEY_W-1:0]  key,
    input  logic [HC_IV_W-1:0]   iv,
    output logic [HC_KEY_W-1:0]  core_key,
    output logic [HC_IV_W-1:0]   core_iv,
    output logic                 core_init,
    output logic                 core_next,
    input  logic                 core_ready,
    input  logic [HC_WORD_W-1:0] core_s,
    input  logic                 core_s_valid,
    input  logic [HC_WORD_W-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [HC_WORD_W-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 ready,
    output logic [31:0]          word_ctr
);

    localparam int CW = $clog2(KS_DEPTH) + 1;

    hc_xor_state_t state;
    hc_xor_state_t state_nxt;

    logic                 settle;
    logic                 outstanding;
    logic                 discard;
    logic                 run;
    logic                 xfer;
    logic                 ks_push;
    logic                 ks_pop;
    logic [HC_WORD_W-1:0] ks_head;
    logic [CW-1:0]        ks_count;

    assign run = (state == HC_XOR_RUN);

    // A start in the same cycle wins, so no word is accepted
    // only to be thrown away by the restart.
    assign din_ready = run && !start
                     && (ks_count != '0)
                     && (!dout_valid || dout_ready);

    assign xfer   = din_valid && din_ready;
    assign ks_pop = xfer;

    // Words for requests made before a restart never enter.
    assign ks_push = core_s_valid && run
                   && !discard && !start;

    // One request in flight; occupancy plus that request
    // never exceeds the buffer depth.
    assign core_next = run && !start && !outstanding
                     && (ks_count < CW'(KS_DEPTH));

    hc_ks_fifo #(
        .KS_DEPTH (KS_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (start),
        .push      (ks_push),
        .push_data (core_s),
        .pop       (ks_pop),
        .head      (ks_head),
        .count     (ks_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HC_XOR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Marks the first WAIT_INIT cycle, where core_ready is stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle <= 1'b0;
        end else begin
            settle <= (state == HC_XOR_INIT);
        end
    end

    // Next-state and FSM-driven outputs.
    always_comb begin
        state_nxt = state;
        core_init = 1'b0;
        ready     = 1'b0;
        unique case (state)
            HC_XOR_IDLE: begin
                if (start) begin
                    state_nxt = HC_XOR_INIT;
                end
            end
            HC_XOR_INIT: begin
                core_init = 1'b1;
                state_nxt = start ? HC_XOR_INIT
                                  : HC_XOR_WAIT_INIT;
            end
            HC_XOR_WAIT_INIT: begin
                if (start) begin
                    state_nxt = HC_XOR_INIT;
                end else if (core_ready && !settle) begin
                    state_nxt = HC_XOR_RUN;
                end
            end
            HC_XOR_RUN: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = HC_XOR_INIT;
                end
            end
            default: begin
                state_nxt = HC_XOR_IDLE;
            end
        endcase
    end

    // Key/IV capture for the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_key <= '0;
            core_iv  <= '0;
        end else if (start) begin
            core_key <= key;
            core_iv  <= iv;
        end
    end

    // Request tracking; a restart with a request in flight
    // leaves one late word to be swallowed.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (start) begin
            outstanding <= 1'b0;
            discard     <= (outstanding || discard)
                         && !core_s_valid;
        end else begin
            if (core_s_valid) begin
                if (discard) begin
                    discard <= 1'b0;
                end else begin
                    outstanding <= 1'b0;
                end
            end
            if (core_next) begin
                outstanding <= 1'b1;
            end
        end
    end

    // Output stage: one-cycle din-to-dout with hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            word_ctr   <= '0;
        end else if (start) begin
            dout_valid <= 1'b0;
            word_ctr   <= '0;
        end else if (xfer) begin
            dout       <= hc_xor_word(din, ks_head);
            dout_valid <= 1'b1;
            word_ctr   <= word_ctr + 32'd1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hc_stream_xor.sv
// Bench for hc_stream_xor with a mock HC core and a
// word-index keystream model.
module tb_hc_stream_xor;

    localparam int          KS_DEPTH = 4;
    localparam logic [31:0] KS_BASE  = 32'hA5A50000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [127:0] iv;
    logic [127:0] core_key;
    logic [127:0] core_iv;
    logic         core_init;
    logic         core_next;
    logic         core_ready   = 1'b0;
    logic [31:0]  core_s       = 32'd0;
    logic         core_s_valid = 1'b0;
    logic [31:0]  din;
    logic         din_valid;
    logic         din_ready;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         ready;
    logic [31:0]  word_ctr;

    int total = 0;
    int bad   = 0;

    hc_stream_xor #(
        .KS_DEPTH (KS_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .key          (key),
        .iv           (iv),
        .core_key     (core_key),
        .core_iv      (core_iv),
        .core_init    (core_init),
        .core_next    (core_next),
        .core_ready   (core_ready),
        .core_s       (core_s),
        .core_s_valid (core_s_valid),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .ready        (ready),
        .word_ctr     (word_ctr)
    );

    always #5 clk = ~clk;

    // Mock core: ready 1030 cycles after init, word n = BASE+n
    // three cycles after each request.
    int          ks_left     = 0;
    logic [31:0] pend        = 32'd0;
    int          n           = 0;
    int          rdy_cnt     = 0;
    int          init_pulses = 0;
    int          next_pulses = 0;
    int          two_out     = 0;
    int          ovf         = 0;
    bit          busy;

    always @(negedge clk) begin
        busy = (ks_left != 0);
        core_s_valid = 1'b0;
        if (ks_left > 0) begin
            ks_left--;
            if (ks_left == 0) begin
                core_s_valid = 1'b1;
                core_s       = pend;
            end
        end
        if (core_next) begin
            next_pulses++;
            if (busy) two_out++;
            pend    = KS_BASE + n;
            n++;
            ks_left = 3;
        end
        if (core_init) begin
            init_pulses++;
            n          = 0;
            rdy_cnt    = 1030;
            core_ready = 1'b0;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) core_ready = 1'b1;
        end
        if (dut.ks_count > KS_DEPTH) ovf++;
    end

    // Scoreboard: k-th word accepted since start is
    // din ^ (BASE + k).
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_v;
    int          idx = 0;

    always @(negedge clk) begin
        if (dout_valid && dout_ready) begin
            got_q.push_back(dout);
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_extra observed=%h required=none",
                       dout);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                total++;
                assert (dout === exp_v) else begin
                    bad++;
                    $error("FAIL sb_dout observed=%h required=%h",
                           dout, exp_v);
                end
            end
        end
        if (reset || start) begin
            exp_q.delete();
            idx = 0;
        end else if (din_valid && din_ready) begin
            exp_q.push_back(din ^ (KS_BASE + 32'(idx)));
            idx++;
        end
    end

    task automatic check(input string tag,
                         input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k,
                            input logic [127:0] v);
        key         = k;
        iv          = v;
        start       = 1'b1;
        next_pulses = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_run(output bit ok, output int early);
        ok    = 1'b0;
        early = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
            if (din_ready) early++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d,
                             output bit ok);
        din       = d;
        din_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (din_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [127:0] k2;
    logic [127:0] v2;
    logic [31:0]  d1, d2, d3, d4, wc0;
    bit           ok;
    int           early;
    int           bp_bad;
    int           to_bad;
    int           stall_bad;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        key        = '0;
        iv         = '0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        @(negedge clk);
        check("rst_dout_valid", 128'(dout_valid), 0);
        check("rst_ready", 128'(ready), 0);
        check("rst_word_ctr", 128'(word_ctr), 0);
        check("rst_core_key", core_key, 0);
        check("rst_core_iv", core_iv, 0);
        check("rst_core_init", 128'(core_init), 0);
        check("rst_core_next", 128'(core_next), 0);
        check("rst_din_ready", 128'(din_ready), 0);
        check("rst_dout", 128'(dout), 0);
        tick();

        // Basic run with key=0, iv=0.
        do_start('0, '0);
        wait_run(ok, early);
        check("basic_run", 128'(ok), 1);
        check("basic_early_din_ready", 128'(early), 0);
        check("basic_init_pulses", 128'(init_pulses), 1);

        // Prefetch cap while idle in RUN.
        repeat (100) tick();
        check("prefetch_next_pulses", 128'(next_pulses),
              128'(KS_DEPTH));
        check("prefetch_count", 128'(dut.ks_count),
              128'(KS_DEPTH));

        got_q.delete();
        push_word(32'h00000000, ok);
        check("basic_push0", 128'(ok), 1);
        push_word(32'h11111111, ok);
        check("basic_push1", 128'(ok), 1);
        tick();
        tick();
        check("basic_ndout", 128'(got_q.size()), 2);
        if (got_q.size() == 2) begin
            check("basic_dout0", 128'(got_q[0]), 128'h A5A50000);
            check("basic_dout1", 128'(got_q[1]), 128'h B4B41110);
        end
        check("basic_word_ctr", 128'(word_ctr), 2);

        // Back-pressure: sink stalls 10 cycles.
        repeat (20) tick();
        d1 = $urandom;
        d2 = $urandom;
        dout_ready = 1'b0;
        got_q.delete();
        wc0 = word_ctr;
        push_word(d1, ok);
        check("bp_first", 128'(ok), 1);
        din       = d2;
        din_valid = 1'b1;
        bp_bad    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (din_ready || !dout_valid ||
                dout !== (d1 ^ (KS_BASE + 32'd2)))
                bp_bad++;
            @(posedge clk);
            #1;
        end
        check("bp_hold", 128'(bp_bad), 0);
        check("bp_word_ctr", 128'(word_ctr), 128'(wc0 + 32'd1));
        check("bp_no_out", 128'(got_q.size()), 0);
        dout_ready = 1'b1;
        push_word(d2, ok);
        check("bp_resume", 128'(ok), 1);
        tick();
        tick();
        check("bp_ndout", 128'(got_q.size()), 2);
        if (got_q.size() == 2) begin
            check("bp_dout0", 128'(got_q[0]),
                  128'(d1 ^ (KS_BASE + 32'd2)));
            check("bp_dout1", 128'(got_q[1]),
                  128'(d2 ^ (KS_BASE + 32'd3)));
        end

        // Restart with a request in flight.
        repeat (20) tick();
        push_word($urandom, ok);
        check("rs_consume", 128'(ok), 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (core_next) begin
                ok = 1'b1;
                break;
            end
        end
        check("rs_next_seen", 128'(ok), 1);
        @(posedge clk);
        #1;
        k2 = {$urandom, $urandom, $urandom, $urandom};
        v2 = {$urandom, $urandom, $urandom, $urandom};
        do_start(k2, v2);
        @(negedge clk);
        check("rs_core_key", core_key, k2);
        check("rs_core_iv", core_iv, v2);
        check("rs_word_ctr", 128'(word_ctr), 0);
        wait_run(ok, early);
        check("rs_run", 128'(ok), 1);
        check("rs_init_pulses", 128'(init_pulses), 2);
        got_q.delete();
        d3 = $urandom;
        push_word(d3, ok);
        check("rs_push", 128'(ok), 1);
        tick();
        check("rs_ndout", 128'(got_q.size()), 1);
        if (got_q.size() == 1)
            check("rs_dout0", 128'(got_q[0]), 128'(d3 ^ KS_BASE));

        // Sustained stream of 1000 words.
        got_q.delete();
        to_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            push_word($urandom, ok);
            if (!ok) to_bad++;
        end
        tick();
        tick();
        check("wrap_timeouts", 128'(to_bad), 0);
        check("wrap_ndout", 128'(got_q.size()), 1000);
        check("wrap_word_ctr", 128'(word_ctr), 1001);

        // Reset in the middle of a stream.
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = $urandom;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mr_dout_valid", 128'(dout_valid), 0);
        check("mr_ready", 128'(ready), 0);
        check("mr_word_ctr", 128'(word_ctr), 0);
        stall_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (din_ready) stall_bad++;
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        check("mr_stall", 128'(stall_bad), 0);
        do_start({$urandom, $urandom, $urandom, $urandom}, '0);
        wait_run(ok, early);
        check("mr_run", 128'(ok), 1);
        check("mr_early_din_ready", 128'(early), 0);
        got_q.delete();
        d4 = $urandom;
        push_word(d4, ok);
        check("mr_push", 128'(ok), 1);
        tick();
        check("mr_ndout", 128'(got_q.size()), 1);
        if (got_q.size() == 1)
            check("mr_dout0", 128'(got_q[0]), 128'(d4 ^ KS_BASE));

        check("never_two_outstanding", 128'(two_out), 0);
        check("no_overflow", 128'(ovf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
